// File: rtl/nic_dma_wb_writer_if.sv
// Wishbone B4 pipelined write bus between the NIC DMA writer (master)
// and the NIC DMA buffer slave port.
interface nic_dma_wb_writer_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    logic        ack;
    logic        stall;

    modport master (output cyc, stb, we, sel, adr, dat, input  ack, stall);
    modport slave  (input  cyc, stb, we, sel, adr, dat, output ack, stall);
endinterface

// File: rtl/nic_dma_wb_writer.sv
// nic_dma_wb_writer: pipelined Wishbone B4 DMA write master.
// Takes a command (start address, word count) plus a 32-bit valid/ready
// stream and issues one single-word pipelined write per stream word,
// bounding the number of un-acked writes to g_MAX_OUTSTANDING.
// Optional ack watchdog: define NIC_DMA_TIMEOUT_EN to enable the abort
// path (err_o pulses with done_o); without it err_o is tied low.
// Reset rst_n is asynchronous and active-high.
module nic_dma_wb_writer #(
    parameter int g_MAX_OUTSTANDING = 4,
    parameter int g_TIMEOUT_CYCLES  = 1024
) (
    input  logic                        clk_sys,
    input  logic                        rst_n,
    input  logic                        cmd_valid_i,
    output logic                        cmd_ready_o,
    input  logic [31:0]                 cmd_addr_i,
    input  logic [15:0]                 cmd_len_i,
    input  logic                        snk_valid_i,
    output logic                        snk_ready_o,
    input  logic [31:0]                 snk_data_i,
    nic_dma_wb_writer_if.master         wb,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        err_o
);
    typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

    state_t      state, state_nxt;
    logic [31:0] adr_q, dat_q;
    logic        stb_q;
    logic [15:0] words_left;    // stream words still to accept
    logic [15:0] stb_left;      // strobes still to be accepted by the slave
    logic [3:0]  outstanding;
    logic [4:0]  out_next;
    logic        done_q, done_nxt;
    logic        cmd_acc, snk_acc, stb_acc, ack_eff, timeout;

    // Parameter range guard
    if (g_MAX_OUTSTANDING < 1 || g_MAX_OUTSTANDING > 15 || g_TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("nic_dma_wb_writer: parameter out of range");
    end

    assign cmd_acc  = cmd_valid_i & (state == IDLE);
    assign stb_acc  = stb_q & ~wb.stall;
    // An ack with nothing outstanding is spurious and ignored
    assign ack_eff  = wb.ack & (outstanding != 4'd0);
    assign out_next = {1'b0, outstanding} + 5'(stb_acc) - 5'(ack_eff);

    // A new word may only be taken if the stb register is free (or being
    // accepted this cycle) and the write it becomes stays within the limit.
    assign snk_ready_o = (state == XFER) && (words_left != 16'd0) &&
                         (!stb_q || !wb.stall) &&
                         (out_next < 5'(g_MAX_OUTSTANDING)) && !timeout;
    assign snk_acc     = snk_valid_i & snk_ready_o;

    assign cmd_ready_o = (state == IDLE);
    assign busy_o      = (state != IDLE);
    assign done_o      = done_q;
    assign wb.cyc      = (state != IDLE);
    assign wb.we       = wb.cyc;
    assign wb.stb      = stb_q;
    assign wb.sel      = 4'hF;
    assign wb.adr      = adr_q;
    assign wb.dat      = dat_q;

`ifdef NIC_DMA_TIMEOUT_EN
    localparam int WD_W = $clog2(g_TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            err_q;

    // Fires on the cycle the watchdog would reach the limit
    assign timeout = (state != IDLE) && (outstanding != 4'd0) && !wb.ack &&
                     (wd_cnt == WD_W'(g_TIMEOUT_CYCLES - 1));
    assign err_o   = err_q;

    // Watchdog: counts ack-less cycles with writes outstanding
    always_ff @(posedge clk_sys or posedge rst_n) begin
        if (rst_n) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= timeout;
            if (state == IDLE || wb.ack || outstanding == 4'd0 || timeout)
                wd_cnt <= '0;
            else
                wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign err_o   = 1'b0;
`endif

    // Next state and completion pulse
    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_acc) begin
                    if (cmd_len_i == 16'd0) done_nxt  = 1'b1;
                    else                    state_nxt = XFER;
                end
            end
            XFER: begin
                if (timeout) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else if (stb_acc && stb_left == 16'd1) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (timeout || out_next == 5'd0) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register, bus datapath and counters
    always_ff @(posedge clk_sys or posedge rst_n) begin
        if (rst_n) begin
            state       <= IDLE;
            done_q      <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            stb_q       <= 1'b0;
            words_left  <= '0;
            stb_left    <= '0;
            outstanding <= '0;
        end else begin
            state  <= state_nxt;
            done_q <= done_nxt;
            if (cmd_acc) begin
                adr_q      <= cmd_addr_i & 32'hFFFF_FFFC;
                words_left <= cmd_len_i;
                stb_left   <= cmd_len_i;
            end
            if (timeout) begin
                stb_q       <= 1'b0;
                outstanding <= '0;
                words_left  <= '0;
                stb_left    <= '0;
            end else begin
                outstanding <= out_next[3:0];
                if (stb_acc) begin
                    adr_q    <= adr_q + 32'd4;
                    stb_left <= stb_left - 16'd1;
                end
                if (snk_acc) begin
                    dat_q      <= snk_data_i;
                    words_left <= words_left - 16'd1;
                    stb_q      <= 1'b1;
                end else if (stb_acc) begin
                    stb_q <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_nic_dma_wb_writer.sv
// Randomized self-checking bench for nic_dma_wb_writer.
// Reference: each transfer must produce writes {addr&~3 + 4*i, word[i]}
// in order, exactly one done pulse, bounded outstanding writes and
// stable stb/adr/dat under stall.
module tb_nic_dma_wb_writer;
    localparam int MAXO = 4;
    localparam int TMO  = 16;

    logic        clk_sys = 1'b0;
    logic        rst_n   = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [31:0] cmd_addr_i  = '0;
    logic [15:0] cmd_len_i   = '0;
    logic        snk_valid_i = 1'b0;
    logic        snk_ready_o;
    logic [31:0] snk_data_i  = '0;
    logic        busy_o, done_o, err_o;

    nic_dma_wb_writer_if wb();

    nic_dma_wb_writer #(.g_MAX_OUTSTANDING(MAXO), .g_TIMEOUT_CYCLES(TMO)) dut (
        .clk_sys(clk_sys), .rst_n(rst_n),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
        .snk_valid_i(snk_valid_i), .snk_ready_o(snk_ready_o), .snk_data_i(snk_data_i),
        .wb(wb), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk_sys = ~clk_sys;

    int n_cmp = 0, n_bad = 0;
    int cyc_n = 0;
    logic [31:0] src_q[$];
    logic [31:0] got_a[$], got_d[$];
    int ack_q[$];
    int lat = 1, stall_pct = 0, vld_pct = 100, stall_force = 0, stall_at = -1;
    bit ack_on = 1'b1, snk_took = 1'b0;
    int first_acc, last_acc, done_cnt, err_cnt, done_cyc, acks, acks_at_done;
    int out_mdl, max_out, viol, busy_seen, cyc_seen, acc_cyc;
    bit done_cyc_low, rdy_at_done, hold;
    logic [31:0] h_adr, h_dat;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic reset_stats();
        got_a.delete(); got_d.delete();
        first_acc = -1; last_acc = -1; done_cnt = 0; err_cnt = 0; done_cyc = -1;
        acks = 0; acks_at_done = 0; out_mdl = 0; max_out = 0; viol = 0;
        busy_seen = 0; cyc_seen = 0; done_cyc_low = 0; rdy_at_done = 0;
    endtask

    // Slave and source drivers: new inputs shortly after each rising edge
    initial begin
        wb.ack = 1'b0; wb.stall = 1'b0;
        forever begin
            @(posedge clk_sys); #1;
            cyc_n++;
            if (ack_q.size() > 0 && ack_q[0] <= cyc_n) begin
                wb.ack = 1'b1; void'(ack_q.pop_front());
            end else wb.ack = 1'b0;
            if (stall_at >= 0 && got_a.size() == stall_at) begin
                stall_force = 3; stall_at = -1;
            end
            if (stall_force > 0) begin
                wb.stall = 1'b1; stall_force--;
            end else wb.stall = ($urandom_range(99) < stall_pct);
            if (!(snk_valid_i && !snk_took && src_q.size() > 0)) begin
                if (src_q.size() > 0 && $urandom_range(99) < vld_pct) begin
                    snk_valid_i = 1'b1; snk_data_i = src_q[0];
                end else begin
                    snk_valid_i = 1'b0; snk_data_i = $urandom;
                end
            end
            snk_took = 1'b0;
        end
    end

    // Monitor: observes the bus mid-cycle
    initial begin
        bit acc, ackd;
        forever begin
            @(negedge clk_sys);
            acc = wb.cyc && wb.stb && !wb.stall;
            if (hold && !(wb.stb && wb.adr == h_adr && wb.dat == h_dat)) viol++;
            hold = wb.cyc && wb.stb && wb.stall; h_adr = wb.adr; h_dat = wb.dat;
            ackd = wb.ack && out_mdl > 0;
            if (acc) begin
                got_a.push_back(wb.adr); got_d.push_back(wb.dat);
                if (ack_on) ack_q.push_back(cyc_n + lat);
                if (first_acc < 0) first_acc = cyc_n;
                last_acc = cyc_n;
                out_mdl++;
            end
            if (ackd) begin acks++; out_mdl--; end
            if (out_mdl > max_out) max_out = out_mdl;
            if (snk_valid_i && snk_ready_o) begin void'(src_q.pop_front()); snk_took = 1'b1; end
            if (done_o) begin
                done_cnt++; done_cyc = cyc_n; done_cyc_low = !wb.cyc;
                acks_at_done = acks; rdy_at_done = cmd_ready_o;
            end
            if (err_o) err_cnt++;
            if (busy_o) busy_seen++;
            if (wb.cyc) cyc_seen++;
        end
    end

    task automatic start_cmd(input logic [31:0] a, input int len);
        @(posedge clk_sys); #1;
        cmd_valid_i = 1'b1; cmd_addr_i = a; cmd_len_i = 16'(len);
        @(negedge clk_sys);
        acc_cyc = cyc_n;
        chk("cmd_ready_at_accept", cmd_ready_o, 1);
        @(posedge clk_sys); #1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic run_xfer(input string nm, input logic [31:0] a, input int len, input bit tchk);
        logic [31:0] exp_d[$];
        logic [31:0] ea;
        int k;
        exp_d = src_q;
        reset_stats();
        start_cmd(a, len);
        for (k = 0; k < 3000 && done_cnt == 0; k++) @(posedge clk_sys);
        if (done_cnt == 0) chk({nm, "_done_timeout"}, 0, 1);
        repeat (5) @(posedge clk_sys);
        chk({nm, "_done_cnt"}, done_cnt, 1);
        chk({nm, "_err"}, err_cnt, 0);
        chk({nm, "_cyc_low_at_done"}, done_cyc_low, 1);
        chk({nm, "_acks_at_done"}, acks_at_done, len);
        chk({nm, "_nwrites"}, got_a.size(), len);
        for (int i = 0; i < len && i < got_a.size(); i++) begin
            ea = {a[31:2], 2'b00} + 32'(4 * i);
            chk($sformatf("%s_adr%0d", nm, i), got_a[i], ea);
            chk($sformatf("%s_dat%0d", nm, i), got_d[i], exp_d[i]);
        end
        chk({nm, "_stall_hold_viol"}, viol, 0);
        chk({nm, "_max_out_ok"}, (max_out <= MAXO), 1);
        chk({nm, "_src_consumed"}, src_q.size(), 0);
        if (tchk) begin
            chk({nm, "_first_lat"}, first_acc - acc_cyc, 2);
            chk({nm, "_thruput"}, last_acc - first_acc, len - 1);
            chk({nm, "_done_lat"}, done_cyc - last_acc, 2);
        end
    endtask

    initial begin
        int len;
        #500000;
        $display("FAIL global_time_limit: got expired expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        int len;
        // reset state
        repeat (3) @(negedge clk_sys);
        chk("rst_cmd_ready", cmd_ready_o, 1);
        chk("rst_snk_ready", snk_ready_o, 0);
        chk("rst_busy_done_err", {busy_o, done_o, err_o}, 0);
        chk("rst_cyc_stb_we", {wb.cyc, wb.stb, wb.we}, 0);
        chk("rst_adr_dat", {wb.adr, wb.dat}, 0);
        chk("rst_sel", wb.sel, 4'hF);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk_sys);

        // two-word write, single-cycle ack
        lat = 1; stall_pct = 0; vld_pct = 100;
        src_q = '{32'hDEADBEEF, 32'hCAFEBABE};
        run_xfer("two", 32'h0, 2, 1'b1);

        // forced 3-cycle stall mid-burst
        for (int i = 0; i < 8; i++) src_q.push_back($urandom);
        stall_at = 3;
        run_xfer("stall", 32'h100, 8, 1'b0);

        // slow acks: outstanding capped
        lat = 10;
        for (int i = 0; i < 8; i++) src_q.push_back($urandom);
        run_xfer("slowack", 32'h2000_0003, 8, 1'b0);
        chk("slowack_max_out", max_out, MAXO);
        lat = 1;

        // zero length
        reset_stats();
        start_cmd(32'h40, 0);
        repeat (4) @(posedge clk_sys);
        chk("len0_done_cnt", done_cnt, 1);
        chk("len0_done_lat", done_cyc - acc_cyc, 1);
        chk("len0_no_cyc", cyc_seen, 0);
        chk("len0_no_busy", busy_seen, 0);
        chk("len0_ready_at_done", rdy_at_done, 1);

        // address wrap
        for (int i = 0; i < 4; i++) src_q.push_back($urandom);
        run_xfer("wrap", 32'hFFFF_FFF8, 4, 1'b1);

        // randomized transfers
        for (int it = 0; it < 8; it++) begin
            len = $urandom_range(1, 12);
            lat = $urandom_range(1, 6);
            stall_pct = $urandom_range(0, 40);
            vld_pct = $urandom_range(50, 100);
            for (int i = 0; i < len; i++) src_q.push_back($urandom);
            run_xfer($sformatf("rnd%0d", it), $urandom, len, 1'b0);
        end
        stall_pct = 0; vld_pct = 100; lat = 1;

        // slave never acks
        ack_on = 1'b0;
        for (int i = 0; i < 6; i++) src_q.push_back($urandom);
        reset_stats();
        start_cmd(32'h200, 6);
        repeat (60) @(posedge clk_sys);
        #2;
        chk("noack_src_left", src_q.size(), 2);
`ifdef NIC_DMA_TIMEOUT_EN
        chk("noack_done", done_cnt, 1);
        chk("noack_err", err_cnt, 1);
        chk("noack_done_lat", done_cyc - first_acc, TMO + 1);
        chk("noack_cyc_low", done_cyc_low, 1);
`else
        chk("noack_done", done_cnt, 0);
        chk("noack_err", err_cnt, 0);
        chk("noack_cyc_high", wb.cyc, 1);
        chk("noack_nwrites", got_a.size(), MAXO);
`endif

        // asynchronous reset mid-transfer
        @(negedge clk_sys); #2;
        rst_n = 1'b1;
        #1;
        chk("arst_bus_drop", {wb.cyc, wb.stb, busy_o}, 0);
        src_q.delete(); ack_q.delete();
        reset_stats();
        repeat (3) @(posedge clk_sys);
        #2 rst_n = 1'b0;
        ack_on = 1'b1;
        repeat (4) @(posedge clk_sys);
        chk("arst_no_done", done_cnt, 0);
        chk("arst_idle_ready", cmd_ready_o, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
